// File: rtl/div_unit_if.sv
// Handshake and operand bundle between the EX stage and the multi-cycle divider.
interface div_unit_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring 32/32 divider returning {remainder, quotient}.
// Define DIV_SIGNED_EN to build in signed (DIV) support; otherwise every divide is unsigned.
module div_unit (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave div_io
);
    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] w_q, w_d;
    logic [31:0] divisor_q, divisor_d;
    logic [63:0] result_q, result_d;

    logic [33:0] diff;
    logic [31:0] op1_mag, op2_mag;
    logic [31:0] quot, rem;
    logic        accept;

    assign accept = (state_q == StFree) && div_io.start_i && !div_io.annul_i;

`ifdef DIV_SIGNED_EN
    logic neg_quot_q, neg_rem_q;
    logic op1_neg, op2_neg;

    assign op1_neg = div_io.signed_div_i & div_io.opdata1_i[31];
    assign op2_neg = div_io.signed_div_i & div_io.opdata2_i[31];
    assign op1_mag = op1_neg ? (32'd0 - div_io.opdata1_i) : div_io.opdata1_i;
    assign op2_mag = op2_neg ? (32'd0 - div_io.opdata2_i) : div_io.opdata2_i;

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    assign quot = neg_quot_q ? (32'd0 - w_q[31:0]) : w_q[31:0];
    assign rem  = neg_rem_q ? (32'd0 - w_q[63:32]) : w_q[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (accept) begin
            neg_quot_q <= op1_neg ^ op2_neg;
            neg_rem_q  <= op1_neg;
        end
    end
`else
    assign op1_mag = div_io.opdata1_i;
    assign op2_mag = div_io.opdata2_i;
    assign quot    = w_q[31:0];
    assign rem     = w_q[63:32];
`endif

    // Partial remainder with the next dividend bit appended, minus the divisor.
    assign diff = w_q[64:31] - {2'b00, divisor_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFree;
            cnt_q     <= 6'd0;
            w_q       <= 65'd0;
            divisor_q <= 32'd0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            w_q       <= w_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        divisor_d = divisor_q;
        result_d  = result_q;

        unique case (state_q)
            StFree: begin
                result_d = 64'd0;
                if (accept) begin
                    divisor_d = op2_mag;
                    w_d       = {33'd0, op1_mag};
                    cnt_d     = 6'd0;
                    state_d   = (div_io.opdata2_i == 32'd0) ? StByZero : StOn;
                end
            end
            StByZero: begin
                state_d = div_io.annul_i ? StFree : StEnd;
            end
            StOn: begin
                if (div_io.annul_i) begin
                    state_d = StFree;
                end else if (cnt_q == 6'd32) begin
                    result_d = {rem, quot};
                    state_d  = StEnd;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    // Borrow means the divisor did not fit: shift in a 0 quotient bit.
                    if (diff[33]) begin
                        w_d = {w_q[63:0], 1'b0};
                    end else begin
                        w_d = {1'b0, diff[31:0], w_q[30:0], 1'b1};
                    end
                end
            end
            StEnd: begin
                if (!div_io.start_i) begin
                    result_d = 64'd0;
                    state_d  = StFree;
                end
            end
            default: begin
                state_d  = StFree;
                result_d = 64'd0;
            end
        endcase
    end

    assign div_io.ready_o  = (state_q == StEnd);
    assign div_io.result_o = result_q;
endmodule
